dac_pattern_player: RTL and testbench

Loops a stored pattern out to one RFSoC DAC tile as an AXI4-Stream master. Software loads up to 512 wide words of DAC samples through a simple write port. The player then arms and starts on the next user SYSREF rising edge, so that playback is phase-aligned to the ADC capture. It sits between the PS register block and the RFDC DAC `s_axis` port, on the same `aclk` as the ADC stream side.

---
 rtl/dac_player_pkg.sv | 12 +
 rtl/dac_pattern_ram.sv | 22 ++
 rtl/dac_pattern_player.sv | 165 ++++++++++++++++
 tb/tb_dac_pattern_player.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/dac_player_pkg.sv
// Shared types and constants for the DAC pattern player.
package dac_player_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    PLAY
  } state_t;

  localparam int LOOP_CNT_BITS = 16;

endpackage

// File: rtl/dac_pattern_ram.sv
// Simple dual-port pattern RAM: one write port, one registered read port (read-before-write).
module dac_pattern_ram #(
  parameter int DEPTH_LOG2 = 9,
  parameter int DATA_W     = 128
) (
  input  logic                  aclk,
  input  logic                  wr_en,
  input  logic [DEPTH_LOG2-1:0] wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic                  rd_en,
  input  logic [DEPTH_LOG2-1:0] rd_addr,
  output logic [DATA_W-1:0]     rd_data
);

  logic [DATA_W-1:0] mem [2**DEPTH_LOG2];

  always_ff @(posedge aclk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/dac_pattern_player.sv
// Loops a stored pattern to an AXI4-Stream DAC port, starting on a SYSREF rising edge.
module dac_pattern_player
  import dac_player_pkg::*;
#(
  parameter int NSAMP       = 8,
  parameter int SAMPLE_BITS = 16,
  parameter int DEPTH_LOG2  = 9
) (
  input  logic                           aclk,
  input  logic                           aresetn,
  input  logic                           wr_en,
  input  logic [DEPTH_LOG2-1:0]          wr_addr,
  input  logic [NSAMP*SAMPLE_BITS-1:0]   wr_data,
  input  logic [DEPTH_LOG2-1:0]          cfg_last,
  input  logic                           start,
  input  logic                           stop,
  input  logic                           sysref,
  output logic [NSAMP*SAMPLE_BITS-1:0]   m_axis_tdata,
  output logic                           m_axis_tvalid,
  input  logic                           m_axis_tready,
  output logic                           busy,
  output logic [LOOP_CNT_BITS-1:0]       loop_count
);

  localparam int W = NSAMP * SAMPLE_BITS;

  state_t                   state_q;
  logic [DEPTH_LOG2-1:0]    last_q;
  logic                     stop_pend_q;
  logic                     busy_q;
  logic                     sysref_q;
  logic                     sysref_qq;
  logic [LOOP_CNT_BITS-1:0] loop_cnt_q;

  // p0: read issue
  logic [DEPTH_LOG2-1:0]    rd_addr_p0;
  logic                     issue_p0;
  // p1: RAM output
  logic                     rd_vld_p1;
  logic                     last_p1;
  logic [W-1:0]             rd_data_p1;
  // p2: two-entry skid buffer, slot0 is the head
  logic [1:0]               occ_p2;
  logic [W-1:0]             slot0_p2;
  logic [W-1:0]             slot1_p2;
  logic                     last0_p2;
  logic                     last1_p2;

  logic                     sysref_rise;
  logic                     pop;
  logic                     pop_last;
  logic                     finish;
  logic [2:0]               occ_sum;

  always_comb begin
    sysref_rise = sysref_q & ~sysref_qq;
    pop         = (occ_p2 != 2'd0) && m_axis_tready;
    pop_last    = pop && last0_p2;
    finish      = (state_q == PLAY) && pop_last && (stop_pend_q || stop);
    // A read may only issue if its word is guaranteed a free slot when it lands.
    occ_sum     = {1'b0, occ_p2} + {2'b00, rd_vld_p1} - {2'b00, pop};
    issue_p0    = (state_q == PLAY) && !finish && (occ_sum <= 3'd1);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= IDLE;
      last_q      <= '0;
      stop_pend_q <= 1'b0;
      busy_q      <= 1'b0;
      sysref_q    <= 1'b0;
      sysref_qq   <= 1'b0;
      loop_cnt_q  <= '0;
      rd_addr_p0  <= '0;
    end else begin
      sysref_q  <= sysref;
      sysref_qq <= sysref_q;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= ARMED;
            busy_q  <= 1'b1;
            last_q  <= cfg_last;
          end
        end
        ARMED: begin
          if (stop) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (sysref_rise) begin
            state_q     <= PLAY;
            loop_cnt_q  <= '0;
            rd_addr_p0  <= '0;
            stop_pend_q <= 1'b0;
          end
        end
        PLAY: begin
          if (finish) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            stop_pend_q <= 1'b0;
          end else if (stop) begin
            stop_pend_q <= 1'b1;
          end
          if (issue_p0)
            rd_addr_p0 <= (rd_addr_p0 == last_q) ? '0 : rd_addr_p0 + DEPTH_LOG2'(1);
          if (pop_last && (loop_cnt_q != {LOOP_CNT_BITS{1'b1}}))
            loop_cnt_q <= loop_cnt_q + LOOP_CNT_BITS'(1);
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  dac_pattern_ram #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .DATA_W     (W)
  ) u_ram (
    .aclk    (aclk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en   (issue_p0),
    .rd_addr (rd_addr_p0),
    .rd_data (rd_data_p1)
  );

  // p1 -> p2: pipeline occupancy; leaving PLAY flushes everything in flight
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rd_vld_p1 <= 1'b0;
      occ_p2    <= 2'd0;
    end else if ((state_q != PLAY) || finish) begin
      rd_vld_p1 <= 1'b0;
      occ_p2    <= 2'd0;
    end else begin
      rd_vld_p1 <= issue_p0;
      occ_p2    <= occ_p2 + {1'b0, rd_vld_p1} - {1'b0, pop};
    end
  end

  always_ff @(posedge aclk) begin
    if (issue_p0) last_p1 <= (rd_addr_p0 == last_q);
    if (rd_vld_p1 && ((occ_p2 == 2'd0) || ((occ_p2 == 2'd1) && pop))) begin
      slot0_p2 <= rd_data_p1;
      last0_p2 <= last_p1;
    end else if (pop) begin
      slot0_p2 <= slot1_p2;
      last0_p2 <= last1_p2;
    end
    if (rd_vld_p1 && (((occ_p2 == 2'd1) && !pop) || ((occ_p2 == 2'd2) && pop))) begin
      slot1_p2 <= rd_data_p1;
      last1_p2 <= last_p1;
    end
  end

  assign m_axis_tvalid = (occ_p2 != 2'd0);
  assign m_axis_tdata  = m_axis_tvalid ? slot0_p2 : '0;
  assign busy          = busy_q;
  assign loop_count    = loop_cnt_q;

endmodule

// File: tb/tb_dac_pattern_player.sv
// Directed and randomized bench for dac_pattern_player against an array-based pattern model.
module tb_dac_pattern_player;

  localparam int NSAMP       = 8;
  localparam int SAMPLE_BITS = 16;
  localparam int DEPTH_LOG2  = 9;
  localparam int W           = NSAMP * SAMPLE_BITS;

  logic                  aclk = 1'b0;
  logic                  aresetn = 1'b0;
  logic                  wr_en = 1'b0;
  logic [DEPTH_LOG2-1:0] wr_addr = '0;
  logic [W-1:0]          wr_data = '0;
  logic [DEPTH_LOG2-1:0] cfg_last = '0;
  logic                  start = 1'b0;
  logic                  stop = 1'b0;
  logic                  sysref = 1'b0;
  logic                  m_axis_tready = 1'b0;
  logic [W-1:0]          m_axis_tdata;
  logic                  m_axis_tvalid;
  logic                  busy;
  logic [15:0]           loop_count;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] mem_model [512];

  always #5 aclk = ~aclk;

  dac_pattern_player #(
    .NSAMP       (NSAMP),
    .SAMPLE_BITS (SAMPLE_BITS),
    .DEPTH_LOG2  (DEPTH_LOG2)
  ) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .cfg_last      (cfg_last),
    .start         (start),
    .stop          (stop),
    .sysref        (sysref),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .busy          (busy),
    .loop_count    (loop_count)
  );

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic wr_word(input int a, input logic [W-1:0] d);
    wr_en   = 1'b1;
    wr_addr = DEPTH_LOG2'(a);
    wr_data = d;
    step();
    wr_en = 1'b0;
    mem_model[a] = d;
  endtask

  function automatic logic [15:0] exp_loops(input int beats, input int len);
    int n;
    n = beats / len;
    return (n > 65535) ? 16'hFFFF : 16'(n);
  endfunction

  // Arm with cfg_last = last, fire one SYSREF edge, and expect word 0 exactly 4 cycles later.
  task automatic arm_and_fire(input int last);
    cfg_last = DEPTH_LOG2'(last);
    start    = 1'b1;
    check("busy_before_start", W'(busy), W'(1'b0));
    step();
    start = 1'b0;
    check("busy_after_start", W'(busy), W'(1'b1));
    step();
    sysref = 1'b1;
    step();
    sysref = 1'b0;
    step();
    step();
    check("tvalid_edge_plus3", W'(m_axis_tvalid), W'(1'b0));
    step();
    check("tvalid_edge_plus4", W'(m_axis_tvalid), W'(1'b1));
  endtask

  // Play until the pass containing beat stop_beat ends; stop is pulsed on that beat's handshake.
  task automatic run_play(input int len, input int stop_beat, input bit rnd);
    int beats;
    int end_beat;
    int cyc;
    int budget;
    bit done;
    bit stalled;
    bit hs;
    logic [W-1:0] held;
    beats    = 0;
    cyc      = 0;
    done     = 1'b0;
    stalled  = 1'b0;
    held     = '0;
    end_beat = (stop_beat / len) * len + len - 1;
    budget   = (end_beat + 1) * 4 + 50;
    while (!done && (cyc < budget)) begin
      m_axis_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      hs   = m_axis_tvalid && m_axis_tready;
      stop = hs && (beats == stop_beat);
      if (stalled) check("stall_hold_data", m_axis_tdata, held);
      if (beats > 0) check("valid_held", W'(m_axis_tvalid), W'(1'b1));
      if (m_axis_tvalid) begin
        check("beat_data", m_axis_tdata, mem_model[beats % len]);
        check("loop_count", W'(loop_count), W'(exp_loops(beats, len)));
      end else begin
        check("tdata_zero_idle", m_axis_tdata, '0);
      end
      stalled = m_axis_tvalid && !m_axis_tready;
      held    = m_axis_tdata;
      step();
      stop = 1'b0;
      if (hs) begin
        if (beats == end_beat) done = 1'b1;
        beats++;
      end
      cyc++;
    end
    m_axis_tready = 1'b0;
    check("play_completed", W'(done), W'(1'b1));
    check("end_tvalid", W'(m_axis_tvalid), W'(1'b0));
    check("end_busy", W'(busy), W'(1'b0));
    check("end_tdata", m_axis_tdata, '0);
    check("end_loop_count", W'(loop_count), W'(exp_loops(end_beat + 1, len)));
  endtask

  initial begin
    int len;
    logic [W-1:0] word;

    // Reset state
    step();
    step();
    check("rst_tvalid", W'(m_axis_tvalid), W'(1'b0));
    check("rst_tdata", m_axis_tdata, '0);
    check("rst_busy", W'(busy), W'(1'b0));
    check("rst_loop_count", W'(loop_count), '0);
    aresetn = 1'b1;
    step();

    // Index-replicated words 0..3, then stop mid-pass on word 1 of the third pass
    for (int i = 0; i < 4; i++) wr_word(i, {NSAMP{16'(i)}});
    arm_and_fire(3);
    run_play(4, 9, 1'b0);

    // Stop on the last-word handshake ends playback at once
    arm_and_fire(3);
    run_play(4, 3, 1'b0);

    // Start then stop while armed; a later SYSREF edge must not start playback
    cfg_last = 9'd3;
    start = 1'b1;
    step();
    start = 1'b0;
    check("armed_busy", W'(busy), W'(1'b1));
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("armed_stop_busy", W'(busy), W'(1'b0));
    sysref = 1'b1;
    step();
    sysref = 1'b0;
    for (int i = 0; i < 8; i++) begin
      m_axis_tready = 1'b1;
      check("post_stop_tvalid", W'(m_axis_tvalid), W'(1'b0));
      check("post_stop_busy", W'(busy), W'(1'b0));
      step();
    end
    m_axis_tready = 1'b0;

    // Random pattern, 50% tready, roughly 1000 beats
    len = $urandom_range(5, 40);
    for (int i = 0; i < len; i++) wr_word(i, {$urandom, $urandom, $urandom, $urandom});
    arm_and_fire(len - 1);
    run_play(len, 1000 + $urandom_range(0, len - 1), 1'b1);

    // Asynchronous reset mid-play, then replay the unchanged RAM contents
    arm_and_fire(len - 1);
    for (int i = 0; i < 5; i++) begin
      m_axis_tready = 1'b1;
      check("pre_reset_data", m_axis_tdata, mem_model[i % len]);
      step();
    end
    #2;
    aresetn = 1'b0;
    #1;
    check("async_rst_tvalid", W'(m_axis_tvalid), W'(1'b0));
    check("async_rst_busy", W'(busy), W'(1'b0));
    check("async_rst_loop_count", W'(loop_count), '0);
    m_axis_tready = 1'b0;
    step();
    step();
    aresetn = 1'b1;
    step();
    arm_and_fire(len - 1);
    run_play(len, 2 * len + 1, 1'b1);

    // Single-word pattern: same word every beat, loop_count saturates at 0xFFFF
    word = {NSAMP{16'hA5A5}};
    wr_word(0, word);
    arm_and_fire(0);
    run_play(1, 65540, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
